// File: rtl/i2so_frame_ctrl.sv
// I2S output frame sequencer: sck divider, stereo sample FIFO,
// prefetch register and start/stop control with underrun accounting.
module i2so_frame_ctrl #(
  parameter int CLK_DIV = 8,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DATA_W-1:0]        smp_lft,
  input  logic [DATA_W-1:0]        smp_rgt,
  input  logic                     smp_vld,
  output logic                     smp_rdy,
  input  logic                     i2so_rtr,
  output logic [DATA_W-1:0]        i2so_lft,
  output logic [DATA_W-1:0]        i2so_rgt,
  output logic                     i2so_sck,
  output logic                     i2si_sck_transition,
  output logic                     i2so_en,
  output logic                     underrun,
  output logic [7:0]               urun_cnt,
  output logic [$clog2(DEPTH):0]   fifo_lvl
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLK_DIV) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_STOP
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem_l [DEPTH];
  logic [DATA_W-1:0] r_mem_r [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [LW-1:0]     r_lvl;
  logic              r_rdy;
  logic [DATA_W-1:0] r_lft;
  logic [DATA_W-1:0] r_rgt;
  logic              r_ien;
  logic              r_urun;
  logic [7:0]        r_ucnt;
  logic [DW-1:0]     r_div;
  logic              r_sck;
  logic              r_tick;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_div_on;
  logic [LW-1:0]     w_lvl_nxt;

  assign w_empty = (r_lvl == '0);
  assign w_push  = smp_vld & r_rdy;
  assign w_pop   = ((r_state == S_PRIME) & en & (r_lvl >= LW'(2)))
                 | ((r_state == S_RUN) & i2so_rtr & ~w_empty);
  assign w_lvl_nxt = r_lvl + LW'(w_push) - LW'(w_pop);
  // Leaving STOP truncates the current half-period at once.
  assign w_div_on = (r_state == S_RUN)
                  | ((r_state == S_STOP) & ~i2so_rtr);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_l[r_wp] <= smp_lft;
      r_mem_r[r_wp] <= smp_rgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
      r_rdy <= 1'b1;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_lvl <= w_lvl_nxt;
      r_rdy <= (w_lvl_nxt != LW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lft   <= '0;
      r_rgt   <= '0;
      r_ien   <= 1'b0;
      r_urun  <= 1'b0;
      r_ucnt  <= '0;
    end else begin
      r_urun <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (en) r_state <= S_PRIME;
        end
        S_PRIME: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (r_lvl >= LW'(2)) begin
            r_state <= S_RUN;
            r_ien   <= 1'b1;
            r_lft   <= r_mem_l[r_rp];
            r_rgt   <= r_mem_r[r_rp];
          end
        end
        S_RUN: begin
          if (!en) r_state <= S_STOP;
          if (i2so_rtr) begin
            if (!w_empty) begin
              r_lft <= r_mem_l[r_rp];
              r_rgt <= r_mem_r[r_rp];
            end else begin
              r_lft  <= '0;
              r_rgt  <= '0;
              r_urun <= 1'b1;
              if (r_ucnt != 8'hFF) r_ucnt <= r_ucnt + 8'd1;
            end
          end
        end
        S_STOP: begin
          if (i2so_rtr) begin
            r_state <= S_IDLE;
            r_ien   <= 1'b0;
            r_lft   <= '0;
            r_rgt   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_sck  <= 1'b0;
      r_tick <= 1'b0;
    end else if (w_div_on) begin
      if (r_div == DW'(CLK_DIV - 1)) begin
        r_div  <= '0;
        r_sck  <= ~r_sck;
        r_tick <= ~r_sck;
      end else begin
        r_div  <= r_div + DW'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_div  <= '0;
      r_sck  <= 1'b0;
      r_tick <= 1'b0;
    end
  end

  assign smp_rdy             = r_rdy;
  assign i2so_lft            = r_lft;
  assign i2so_rgt            = r_rgt;
  assign i2so_sck            = r_sck;
  assign i2si_sck_transition = r_tick;
  assign i2so_en             = r_ien;
  assign underrun            = r_urun;
  assign urun_cnt            = r_ucnt;
  assign fifo_lvl            = r_lvl;

endmodule

// File: tb/tb_i2so_frame_ctrl.sv
// Randomized bench for i2so_frame_ctrl against a queue-based
// frame model; sck expected from elapsed cycles since RUN entry.
module tb_i2so_frame_ctrl;

  localparam int CLK_DIV = 8;
  localparam int DEPTH   = 4;
  localparam int DATA_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [DATA_W-1:0] smp_lft = '0;
  logic [DATA_W-1:0] smp_rgt = '0;
  logic              smp_vld = 1'b0;
  logic              smp_rdy;
  logic              i2so_rtr = 1'b0;
  logic [DATA_W-1:0] i2so_lft;
  logic [DATA_W-1:0] i2so_rgt;
  logic              i2so_sck;
  logic              i2si_sck_transition;
  logic              i2so_en;
  logic              underrun;
  logic [7:0]        urun_cnt;
  logic [2:0]        fifo_lvl;

  int n_vec = 0;
  int n_err = 0;

  i2so_frame_ctrl #(
    .CLK_DIV(CLK_DIV),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .en                 (en),
    .smp_lft            (smp_lft),
    .smp_rgt            (smp_rgt),
    .smp_vld            (smp_vld),
    .smp_rdy            (smp_rdy),
    .i2so_rtr           (i2so_rtr),
    .i2so_lft           (i2so_lft),
    .i2so_rgt           (i2so_rgt),
    .i2so_sck           (i2so_sck),
    .i2si_sck_transition(i2si_sck_transition),
    .i2so_en            (i2so_en),
    .underrun           (underrun),
    .urun_cnt           (urun_cnt),
    .fifo_lvl           (fifo_lvl)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 prime, 2 run, 3 stop.
  int          m_mode = 0;
  logic [31:0] m_q[$];
  logic [15:0] m_l = '0;
  logic [15:0] m_r = '0;
  int          m_n = 0;
  int          m_ucnt = 0;
  logic        m_urun = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int nm;
    int sz;
    bit push;
    logic [31:0] pd;
    if (!rst_n) begin
      m_mode = 0;
      m_q.delete();
      m_l = '0;
      m_r = '0;
      m_n = 0;
      m_ucnt = 0;
      m_urun = 1'b0;
    end else begin
      sz = m_q.size();
      push = smp_vld && (sz < DEPTH);
      pd = {smp_lft, smp_rgt};
      nm = m_mode;
      m_urun = 1'b0;
      case (m_mode)
        0: if (en) nm = 1;
        1: begin
          if (!en) nm = 0;
          else if (sz >= 2) begin
            {m_l, m_r} = m_q.pop_front();
            nm = 2;
          end
        end
        2: begin
          if (i2so_rtr) begin
            if (sz > 0) {m_l, m_r} = m_q.pop_front();
            else begin
              m_l = '0;
              m_r = '0;
              m_urun = 1'b1;
              if (m_ucnt < 255) m_ucnt++;
            end
          end
          if (!en) nm = 3;
        end
        default: begin
          if (i2so_rtr) begin
            nm = 0;
            m_l = '0;
            m_r = '0;
          end
        end
      endcase
      if (nm >= 2 && m_mode < 2) m_n = 0;
      else if (nm >= 2) m_n++;
      else m_n = 0;
      m_mode = nm;
      if (push) m_q.push_back(pd);
    end
  end

  logic        e_sck;
  logic        e_tick;
  logic [47:0] dut_v;
  logic [47:0] mdl_v;

  always_comb begin
    e_sck  = (m_mode >= 2) && (((m_n / CLK_DIV) % 2) == 1);
    e_tick = (m_mode >= 2) && (m_n >= CLK_DIV)
          && ((m_n % (2 * CLK_DIV)) == CLK_DIV);
    dut_v = {i2so_lft, i2so_rgt, i2so_sck, i2si_sck_transition,
             i2so_en, underrun, urun_cnt, fifo_lvl, smp_rdy};
    mdl_v = {m_l, m_r, e_sck, e_tick, (m_mode >= 2), m_urun,
             8'(m_ucnt), 3'(m_q.size()), (m_q.size() != DEPTH)};
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (dut_v !== mdl_v) begin
      n_err++;
      $display("FAIL reset_state dut=%h exp=%h", dut_v, mdl_v);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (smp_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_rdy got=%b exp=1", smp_rdy);
    end
  endtask

  task automatic test_start();
    int k0;
    int k1;
    int k2;
    k0 = -1;
    k1 = -1;
    k2 = -1;
    smp_vld = 1'b1;
    smp_lft = 16'h1111;
    smp_rgt = 16'h2222;
    @(negedge clk);
    smp_lft = 16'h3333;
    smp_rgt = 16'h4444;
    @(negedge clk);
    smp_vld = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_vec++;
      if (dut_v !== mdl_v) begin
        n_err++;
        $display("FAIL start cyc=%0d dut=%h exp=%h", i, dut_v, mdl_v);
      end
      if (k0 < 0 && i2so_en) k0 = i;
      else if (k0 >= 0 && i2si_sck_transition) begin
        if (k1 < 0) k1 = i;
        else if (k2 < 0) k2 = i;
      end
    end
    n_vec++;
    if (i2so_lft !== 16'h1111 || i2so_rgt !== 16'h2222) begin
      n_err++;
      $display("FAIL start_word got=%h/%h exp=1111/2222",
               i2so_lft, i2so_rgt);
    end
    n_vec++;
    if (k0 < 0 || k1 - k0 != CLK_DIV) begin
      n_err++;
      $display("FAIL first_tick got=%0d exp=%0d", k1 - k0, CLK_DIV);
    end
    n_vec++;
    if (k1 < 0 || k2 - k1 != 2 * CLK_DIV) begin
      n_err++;
      $display("FAIL tick_period got=%0d exp=%0d", k2 - k1, 2 * CLK_DIV);
    end
  endtask

  task automatic test_feed();
    i2so_rtr = 1'b1;
    @(negedge clk);
    i2so_rtr = 1'b0;
    n_vec++;
    if (i2so_lft !== 16'h3333 || i2so_rgt !== 16'h4444
        || fifo_lvl !== 3'd0) begin
      n_err++;
      $display("FAIL feed got=%h/%h lvl=%0d exp=3333/4444 lvl=0",
               i2so_lft, i2so_rgt, fifo_lvl);
    end
  endtask

  task automatic test_underrun();
    i2so_rtr = 1'b1;
    @(negedge clk);
    i2so_rtr = 1'b0;
    n_vec++;
    if (underrun !== 1'b1 || urun_cnt !== 8'd1 || i2so_lft !== '0
        || i2so_rgt !== '0) begin
      n_err++;
      $display("FAIL underrun got=%b cnt=%0d lft=%h exp=1 cnt=1 lft=0",
               underrun, urun_cnt, i2so_lft);
    end
    @(negedge clk);
    n_vec++;
    if (underrun !== 1'b0) begin
      n_err++;
      $display("FAIL underrun_pulse got=%b exp=0", underrun);
    end
    for (int i = 0; i < 300; i++) begin
      i2so_rtr = 1'($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_vec++;
      if (dut_v !== mdl_v) begin
        n_err++;
        $display("FAIL urun_run cyc=%0d dut=%h exp=%h", i, dut_v, mdl_v);
      end
    end
    repeat (300) begin
      i2so_rtr = 1'b1;
      @(negedge clk);
    end
    i2so_rtr = 1'b0;
    n_vec++;
    if (urun_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL urun_sat got=%0d exp=255", urun_cnt);
    end
  endtask

  task automatic test_full();
    smp_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      smp_lft = 16'($urandom);
      smp_rgt = 16'($urandom);
      @(negedge clk);
    end
    smp_vld = 1'b0;
    n_vec++;
    if (smp_rdy !== 1'b0 || fifo_lvl !== 3'd4) begin
      n_err++;
      $display("FAIL full got rdy=%b lvl=%0d exp rdy=0 lvl=4",
               smp_rdy, fifo_lvl);
    end
    i2so_rtr = 1'b1;
    @(negedge clk);
    smp_vld = 1'b1;
    smp_lft = 16'hA5A5;
    smp_rgt = 16'h5A5A;
    @(negedge clk);
    smp_vld = 1'b0;
    i2so_rtr = 1'b0;
    n_vec++;
    if (fifo_lvl !== 3'd3 || dut_v !== mdl_v) begin
      n_err++;
      $display("FAIL push_pop lvl=%0d dut=%h exp lvl=3 %h",
               fifo_lvl, dut_v, mdl_v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      smp_vld  = 1'($urandom_range(0, 1));
      smp_lft  = 16'($urandom);
      smp_rgt  = 16'($urandom);
      i2so_rtr = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      n_vec++;
      if (dut_v !== mdl_v) begin
        n_err++;
        $display("FAIL random cyc=%0d dut=%h exp=%h", i, dut_v, mdl_v);
      end
    end
    smp_vld = 1'b0;
    i2so_rtr = 1'b0;
  endtask

  task automatic test_stop();
    int rises;
    logic prev;
    logic [2:0] lvl0;
    rises = 0;
    smp_vld = 1'b1;
    repeat (2) begin
      smp_lft = 16'($urandom);
      smp_rgt = 16'($urandom);
      @(negedge clk);
    end
    smp_vld = 1'b0;
    @(negedge clk);
    en = 1'b0;
    prev = i2so_sck;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i2so_sck && !prev) rises++;
      prev = i2so_sck;
      n_vec++;
      if (dut_v !== mdl_v) begin
        n_err++;
        $display("FAIL stop cyc=%0d dut=%h exp=%h", i, dut_v, mdl_v);
      end
    end
    n_vec++;
    if (rises < 2 || i2so_en !== 1'b1) begin
      n_err++;
      $display("FAIL stop_sck rises=%0d en=%b exp>=2 en=1", rises, i2so_en);
    end
    lvl0 = fifo_lvl;
    i2so_rtr = 1'b1;
    @(negedge clk);
    i2so_rtr = 1'b0;
    n_vec++;
    if (i2so_en !== 1'b0 || i2so_sck !== 1'b0 || fifo_lvl !== lvl0
        || i2so_lft !== '0 || dut_v !== mdl_v) begin
      n_err++;
      $display("FAIL stop_idle en=%b sck=%b lvl=%0d exp 0 0 %0d",
               i2so_en, i2so_sck, fifo_lvl, lvl0);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    smp_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      smp_lft = 16'($urandom);
      smp_rgt = 16'($urandom);
      @(negedge clk);
    end
    smp_vld = 1'b0;
    n_vec++;
    if (i2so_en !== 1'b1) begin
      n_err++;
      $display("FAIL rerun en=%b exp=1", i2so_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (i2so_en !== 1'b0 || i2so_sck !== 1'b0 || fifo_lvl !== 3'd0
        || i2so_lft !== '0 || dut_v !== mdl_v) begin
      n_err++;
      $display("FAIL reset_mid dut=%h exp=%h", dut_v, mdl_v);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (smp_rdy !== 1'b1 || dut_v !== mdl_v) begin
      n_err++;
      $display("FAIL reset_release dut=%h exp=%h", dut_v, mdl_v);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_feed();
    test_underrun();
    test_full();
    test_random();
    test_stop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
